fft_stream_bridge: RTL and testbench
====================================

FFT_STREAM_BRIDGE -- requirements
Module: fft_stream_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 32, sample width in bits.
REQ-002 SHALL have parameter ADDR_W, default 12, sample RAM address width (depth 2^ADDR_W).
REQ-003 SHALL have ports i_clk (in, 1, clock) and i_rstn (in, 1, reset); i_rstn is asynchronous, active-low; all logic is clocked by i_clk.
REQ-004 SHALL have port i_samples_number (in, ADDR_W+1): frame length N, sampled on IDLE->LOAD.
REQ-005 SHALL have port i_bitrev_en (in, 1): bit-reversed RAM write addressing, sampled on IDLE->LOAD.
REQ-006 SHALL have input stream ports i_s_tdata (in, DATA_W), i_s_tvalid (in, 1), i_s_tlast (in, 1) and o_s_tready (out, 1).
REQ-007 SHALL have output stream ports o_m_tdata (out, DATA_W), o_m_tvalid (out, 1), o_m_tlast (out, 1) and i_m_tready (in, 1).
REQ-008 SHALL have RAM ports o_ram_addr (out, ADDR_W), o_ram_wdata (out, DATA_W), o_ram_we (out, 1), o_ram_re (out, 1) and i_ram_rdata (in, DATA_W); RAM read latency is exactly 1 cycle.
REQ-009 SHALL have control ports o_data_loaded (out, 1, one-cycle pulse), i_calc_end (in, 1, FFT result ready), o_busy (out, 1, state != IDLE) and o_err_len (out, 1, sticky frame-length error).

Function
REQ-010 SHALL implement states IDLE, LOAD, WAIT_CALC and UNLOAD.
REQ-011 IDLE SHALL drive o_s_tready=1; a beat with i_s_tvalid=1 SHALL latch N and bitrev, clear o_err_len, write the beat at index 0 and enter LOAD.
REQ-012 An N value of 0 or above 2^ADDR_W SHALL be treated as 2^ADDR_W.
REQ-013 LOAD SHALL drive o_s_tready=1 and write each accepted beat (tvalid&tready) in the same cycle: o_ram_we=1, o_ram_wdata=i_s_tdata, o_ram_addr=index, or the ADDR_W-bit reversal of index when bitrev=1.
REQ-014 The index SHALL increment only on accepted beats; stalls (tvalid=0) SHALL hold the index with o_ram_we=0.
REQ-015 On the accepted beat with index N-1 the block SHALL pulse o_data_loaded, clear the index and enter WAIT_CALC; o_s_tready SHALL be 0 from the next cycle.
REQ-016 If i_s_tlast=1 on an accepted beat with index < N-1, the block SHALL set o_err_len and behave as in REQ-015 (frame truncated).
REQ-017 If i_s_tlast=0 on the beat with index N-1, the block SHALL set o_err_len; excess beats SHALL not be accepted.
REQ-018 WAIT_CALC SHALL hold all outputs inactive and enter UNLOAD on the first cycle with i_calc_end=1.
REQ-019 UNLOAD SHALL read indices 0..N-1 in linear order; a read (o_ram_re=1) SHALL be issued only when (output buffer occupancy + reads in flight) < 2.
REQ-020 The output buffer SHALL be 2 entries deep, so full throughput (1 beat/cycle) is sustained while i_m_tready=1 and no beat is lost or duplicated under backpressure.
REQ-021 o_m_tdata and o_m_tlast SHALL be held stable while o_m_tvalid=1 and i_m_tready=0.
REQ-022 o_m_tlast SHALL be 1 only on the beat for index N-1; after that beat is accepted the block SHALL enter IDLE.
REQ-023 o_ram_we and o_ram_re SHALL never both be 1 in the same cycle.
REQ-024 i_calc_end outside WAIT_CALC SHALL be ignored.

Reset
REQ-025 While i_rstn=0 the block SHALL be in IDLE with index, buffer and in-flight count cleared, and o_s_tready=0, o_m_tvalid=0, o_m_tlast=0, o_ram_we=0, o_ram_re=0, o_data_loaded=0, o_busy=0 and o_err_len=0; data outputs SHALL be 0.
REQ-026 Reset asserted in any state SHALL abort the frame, with no partial output completed; o_s_tready SHALL rise in the first cycle after deassertion.

Structure
REQ-027 Package fft_bridge_pkg SHALL hold the state enum (bridge_state_t) and a bit-reverse function parametrised on ADDR_W.
REQ-028 The 2-entry output buffer SHALL be a sub-module fft_bridge_skid (DATA_W+1 bits wide, carrying tdata and tlast).

Verification
REQ-029 Verification SHALL cover: ADDR_W=4, N=16, bitrev=0, continuous 16 beats with tlast on the last beat -> RAM addresses 0..15, o_data_loaded pulses on beat 16, o_err_len=0.
REQ-030 Verification SHALL cover: bitrev=1, N=16 -> write addresses 0,8,4,12,2,...,15 in beat order.
REQ-031 Verification SHALL cover: N=8 with tlast on beat 5 -> o_err_len=1, 5 writes, WAIT_CALC entered; with tlast absent on beat 8 -> o_err_len=1 and o_s_tready=0 afterwards.
REQ-032 Verification SHALL cover: unload N=16 with i_m_tready toggling 1,0,0,1 -> 16 beats in order 0..15, tlast only on beat 15, tdata stable during stalls.
REQ-033 Verification SHALL cover: unload with i_m_tready=1 constantly -> 16 consecutive output beats after a 2-cycle initial latency.
REQ-034 Verification SHALL cover: reset asserted mid-UNLOAD at beat 7 -> all outputs at reset values; a new frame then loads correctly.

Source files
------------

// File: rtl/fft_bridge_pkg.sv
// rtl/fft_bridge_pkg.sv - shared state type and address helper for the FFT stream bridge
package fft_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_CALC,
        ST_UNLOAD
    } bridge_state_t;

    localparam int unsigned BR_MAX_W = 16;

    // Reverses the low addr_w bits of idx; the caller truncates to its own width.
    function automatic logic [BR_MAX_W-1:0] bit_reverse(input logic [BR_MAX_W-1:0] idx,
                                                        input int unsigned addr_w);
        logic [BR_MAX_W-1:0] rev;
        rev = {<<{idx}};
        return rev >> (BR_MAX_W - addr_w);
    endfunction

endpackage

// File: rtl/fft_bridge_skid.sv
// rtl/fft_bridge_skid.sv - two-entry output buffer between the RAM read port and the output stream
module fft_bridge_skid #(
    parameter int WIDTH = 33
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tvalid,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tvalid,
    input  logic             i_tready,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       count;
    logic             pop;

    assign pop = o_tvalid & i_tready;

    // The writer never pushes into a full buffer: reads are credit-limited upstream.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            case ({i_tvalid, pop})
                2'b10: begin
                    if (count == 2'd0) head <= i_tdata;
                    else               tail <= i_tdata;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= i_tdata;
                    end else begin
                        head <= tail;
                        tail <= i_tdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_tdata  = head;
    assign o_tvalid = (count != 2'd0);
    assign o_count  = count;

endmodule

// File: rtl/fft_stream_bridge.sv
// rtl/fft_stream_bridge.sv - streams a frame into sample RAM, waits for the FFT, streams it back out
module fft_stream_bridge
    import fft_bridge_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [ADDR_W:0]   i_samples_number,
    input  logic              i_bitrev_en,
    input  logic [DATA_W-1:0] i_s_tdata,
    input  logic              i_s_tvalid,
    input  logic              i_s_tlast,
    output logic              o_s_tready,
    output logic [DATA_W-1:0] o_m_tdata,
    output logic              o_m_tvalid,
    output logic              o_m_tlast,
    input  logic              i_m_tready,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    output logic              o_ram_we,
    output logic              o_ram_re,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_data_loaded,
    input  logic              i_calc_end,
    output logic              o_busy,
    output logic              o_err_len
);

    bridge_state_t     state;
    logic [ADDR_W-1:0] idx, n_last, rd_idx, cur_last, waddr;
    logic              bitrev, cur_bitrev, s_tready, err_len;
    logic              rd_done, inflight, inflight_last;
    logic              accept, at_last, frame_end, frame_err, ram_re, pop;
    logic [1:0]        skid_count;
    logic [2:0]        credit;
    logic [DATA_W:0]   skid_out;
    logic              m_tvalid;

    // In IDLE the first beat must already see the frame settings being latched.
    always_comb begin
        cur_last   = n_last;
        cur_bitrev = bitrev;
        if (state == ST_IDLE) begin
            cur_last   = i_samples_number[ADDR_W] ? '1 : i_samples_number[ADDR_W-1:0] - ADDR_W'(1);
            cur_bitrev = i_bitrev_en;
        end
    end

    assign accept    = s_tready & i_s_tvalid;
    assign at_last   = (idx == cur_last);
    assign frame_end = accept & (at_last | i_s_tlast);
    assign frame_err = accept & (at_last != i_s_tlast);
    assign waddr     = cur_bitrev ? ADDR_W'(bit_reverse(BR_MAX_W'(idx), ADDR_W)) : idx;

    // A beat leaving this cycle frees its slot, which keeps reads back-to-back.
    assign pop    = m_tvalid & i_m_tready;
    assign credit = 3'(skid_count) + 3'(inflight) - 3'(pop);
    assign ram_re = (state == ST_UNLOAD) & ~rd_done & (credit < 3'd2);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state         <= ST_IDLE;
            idx           <= '0;
            n_last        <= '0;
            bitrev        <= 1'b0;
            s_tready      <= 1'b0;
            err_len       <= 1'b0;
            rd_idx        <= '0;
            rd_done       <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight <= ram_re;
            if (ram_re) inflight_last <= (rd_idx == n_last);
            case (state)
                ST_IDLE: begin
                    s_tready <= 1'b1;
                    idx      <= '0;
                    if (accept) begin
                        n_last  <= cur_last;
                        bitrev  <= i_bitrev_en;
                        err_len <= frame_err;
                        if (frame_end) begin
                            state    <= ST_WAIT_CALC;
                            s_tready <= 1'b0;
                        end else begin
                            idx   <= ADDR_W'(1);
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (frame_err) err_len <= 1'b1;
                        if (frame_end) begin
                            state    <= ST_WAIT_CALC;
                            s_tready <= 1'b0;
                            idx      <= '0;
                        end else begin
                            idx <= idx + ADDR_W'(1);
                        end
                    end
                end
                ST_WAIT_CALC: begin
                    if (i_calc_end) begin
                        state   <= ST_UNLOAD;
                        rd_idx  <= '0;
                        rd_done <= 1'b0;
                    end
                end
                ST_UNLOAD: begin
                    if (ram_re) begin
                        if (rd_idx == n_last) rd_done <= 1'b1;
                        else                  rd_idx  <= rd_idx + ADDR_W'(1);
                    end
                    if (pop && o_m_tlast) begin
                        state    <= ST_IDLE;
                        s_tready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fft_bridge_skid #(
        .WIDTH (DATA_W + 1)
    ) u_skid (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_tdata  ({inflight_last, i_ram_rdata}),
        .i_tvalid (inflight),
        .o_tdata  (skid_out),
        .o_tvalid (m_tvalid),
        .i_tready (i_m_tready),
        .o_count  (skid_count)
    );

    assign o_s_tready    = s_tready;
    assign o_m_tdata     = skid_out[DATA_W-1:0];
    assign o_m_tvalid    = m_tvalid;
    assign o_m_tlast     = skid_out[DATA_W] & m_tvalid;
    assign o_ram_we      = accept;
    assign o_ram_wdata   = accept ? i_s_tdata : '0;
    assign o_ram_re      = ram_re;
    assign o_ram_addr    = accept ? waddr : (ram_re ? rd_idx : '0);
    assign o_data_loaded = frame_end;
    assign o_busy        = (state != ST_IDLE);
    assign o_err_len     = err_len;

endmodule

// File: tb/tb_fft_stream_bridge.sv
// tb/tb_fft_stream_bridge.sv - randomized self-checking bench for fft_stream_bridge
module tb_fft_stream_bridge;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [AW:0]   samples = '0;
    logic          bitrev_en = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tlast;
    logic          m_tready = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          ram_we, ram_re;
    logic          data_loaded, busy, err_len;
    logic          calc_end = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [DW-1:0] ram       [DEPTH];
    logic [DW-1:0] model_mem [DEPTH];
    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    logic [DW-1:0] sent_q    [$];
    logic [DW:0]   out_q     [$];
    int            out_cyc   [$];
    int            dl_count, dl_beat;
    bit            prev_stall = 1'b0;
    logic [DW:0]   prev_beat;
    bit            br_e;

    fft_stream_bridge #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .i_clk            (clk),
        .i_rstn           (rstn),
        .i_samples_number (samples),
        .i_bitrev_en      (bitrev_en),
        .i_s_tdata        (s_tdata),
        .i_s_tvalid       (s_tvalid),
        .i_s_tlast        (s_tlast),
        .o_s_tready       (s_tready),
        .o_m_tdata        (m_tdata),
        .o_m_tvalid       (m_tvalid),
        .o_m_tlast        (m_tlast),
        .i_m_tready       (m_tready),
        .o_ram_addr       (ram_addr),
        .o_ram_wdata      (ram_wdata),
        .o_ram_we         (ram_we),
        .o_ram_re         (ram_re),
        .i_ram_rdata      (ram_rdata),
        .o_data_loaded    (data_loaded),
        .i_calc_end       (calc_end),
        .o_busy           (busy),
        .o_err_len        (err_len)
    );

    always #5 clk = ~clk;

    // Single-port sample RAM with one cycle of read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) ram[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= ram[ram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_addr(input int j, input bit br);
        int r = 0;
        if (!br) return j;
        for (int b = 0; b < AW; b++) r = r * 2 + ((j >> b) & 1);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rstn) begin
            chk("we_re_exclusive", 64'(ram_we & ram_re), 64'd0);
            if (ram_we) begin
                wr_addr_q.push_back(ram_addr);
                wr_data_q.push_back(ram_wdata);
            end
            if (data_loaded) begin
                dl_count++;
                dl_beat = wr_addr_q.size();
            end
            if (prev_stall) chk("m_hold", 64'({m_tvalid, m_tlast, m_tdata}), 64'({1'b1, prev_beat}));
            if (m_tvalid && m_tready) begin
                out_q.push_back({m_tlast, m_tdata});
                out_cyc.push_back(cyc);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = {m_tlast, m_tdata};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_s_tready"}, 64'(s_tready), 64'd0);
        chk({tag, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
        chk({tag, "_m_tlast"}, 64'(m_tlast), 64'd0);
        chk({tag, "_m_tdata"}, 64'(m_tdata), 64'd0);
        chk({tag, "_ram_we"}, 64'(ram_we), 64'd0);
        chk({tag, "_ram_re"}, 64'(ram_re), 64'd0);
        chk({tag, "_ram_addr"}, 64'(ram_addr), 64'd0);
        chk({tag, "_ram_wdata"}, 64'(ram_wdata), 64'd0);
        chk({tag, "_data_loaded"}, 64'(data_loaded), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_err_len"}, 64'(err_len), 64'd0);
    endtask

    task automatic load_frame(input int n_cfg, input bit br, input int beats, input int last_at, input bit gaps);
        int k = 0;
        int guard = 0;
        wr_addr_q.delete();
        wr_data_q.delete();
        sent_q.delete();
        dl_count  = 0;
        dl_beat   = -1;
        samples   = (AW+1)'(n_cfg);
        bitrev_en = br;
        while (k < beats && guard < 400) begin
            @(posedge clk); #1;
            guard++;
            if (gaps && $urandom_range(3) == 0) begin
                s_tvalid = 1'b0;
            end else begin
                s_tvalid = 1'b1;
                s_tdata  = $urandom;
                s_tlast  = (k == last_at);
            end
            @(negedge clk);
            if (s_tvalid && s_tready) begin
                sent_q.push_back(s_tdata);
                k++;
            end else if (k > 0 && !s_tready) begin
                break;
            end
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic check_load(input string tag, input int exp_beats, input bit br, input bit exp_err);
        chk({tag, "_beats"}, 64'(sent_q.size()), 64'(exp_beats));
        chk({tag, "_writes"}, 64'(wr_addr_q.size()), 64'(exp_beats));
        for (int j = 0; j < exp_beats && j < wr_addr_q.size() && j < sent_q.size(); j++) begin
            chk({tag, "_waddr"}, 64'(wr_addr_q[j]), 64'(model_addr(j, br)));
            chk({tag, "_wdata"}, 64'(wr_data_q[j]), 64'(sent_q[j]));
        end
        chk({tag, "_loaded_pulses"}, 64'(dl_count), 64'd1);
        chk({tag, "_loaded_beat"}, 64'(dl_beat), 64'(exp_beats));
        @(negedge clk);
        chk({tag, "_err_len"}, 64'(err_len), 64'(exp_err));
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_s_tready"}, 64'(s_tready), 64'd0);
        for (int j = 0; j < sent_q.size(); j++) model_mem[model_addr(j, br)] = sent_q[j];
    endtask

    task automatic wait_calc_quiet(input string tag);
        repeat (3) begin
            @(negedge clk);
            chk({tag, "_wait_m_tvalid"}, 64'(m_tvalid), 64'd0);
            chk({tag, "_wait_ram_re"}, 64'(ram_re), 64'd0);
            chk({tag, "_wait_ram_we"}, 64'(ram_we), 64'd0);
            chk({tag, "_wait_busy"}, 64'(busy), 64'd1);
        end
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic unload(input string tag, input int n, input int mode, input int abort_at);
        int guard = 0;
        int i = 0;
        int t0;
        logic [3:0] pat;
        pat = 4'b1001;
        out_q.delete();
        out_cyc.delete();
        @(posedge clk); #1;
        calc_end = 1'b1;
        m_tready = (mode == 0);
        t0 = cyc;
        @(posedge clk); #1;
        calc_end = 1'b0;
        while (out_q.size() < n && guard < 400) begin
            if (abort_at >= 0 && out_q.size() == abort_at) begin
                rstn = 1'b0;
                return;
            end
            case (mode)
                0:       m_tready = 1'b1;
                1:       m_tready = pat[i % 4];
                default: m_tready = 1'($urandom_range(1));
            endcase
            i++;
            @(posedge clk); #1;
            guard++;
        end
        m_tready = 1'b0;
        chk({tag, "_out_beats"}, 64'(out_q.size()), 64'(n));
        for (int k = 0; k < n && k < out_q.size(); k++) begin
            chk({tag, "_out_data"}, 64'(out_q[k][DW-1:0]), 64'(model_mem[k]));
            chk({tag, "_out_last"}, 64'(out_q[k][DW]), 64'(k == n - 1));
        end
        if (mode == 0 && out_q.size() == n) begin
            chk({tag, "_first_latency"}, 64'(out_cyc[0] - t0), 64'd3);
            chk({tag, "_burst_span"}, 64'(out_cyc[n-1] - out_cyc[0]), 64'(n - 1));
        end
        @(negedge clk);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        chk({tag, "_idle_s_tready"}, 64'(s_tready), 64'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("por");
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("por_s_tready_rise", 64'(s_tready), 64'd1);

        @(posedge clk); #1;
        calc_end = 1'b1;
        @(posedge clk); #1;
        calc_end = 1'b0;
        @(negedge clk);
        chk("idle_calc_end_busy", 64'(busy), 64'd0);
        chk("idle_calc_end_m_tvalid", 64'(m_tvalid), 64'd0);

        load_frame(16, 1'b0, 16, 15, 1'b0);
        check_load("A", 16, 1'b0, 1'b0);
        wait_calc_quiet("A");
        unload("A", 16, 0, -1);

        load_frame(16, 1'b1, 16, 15, 1'b1);
        check_load("B", 16, 1'b1, 1'b0);
        unload("B", 16, 1, -1);

        load_frame(8, 1'b0, 5, 4, 1'b1);
        check_load("C", 5, 1'b0, 1'b1);
        wait_calc_quiet("C");
        unload("C", 8, 2, -1);

        load_frame(8, 1'b0, 12, -1, 1'b0);
        check_load("D", 8, 1'b0, 1'b1);
        unload("D", 8, 2, -1);

        br_e = 1'($urandom_range(1));
        load_frame(0, br_e, 16, 15, 1'b1);
        check_load("E", 16, br_e, 1'b0);
        unload("E", 16, 2, 7);
        @(negedge clk);
        check_reset_vals("mid_unload");
        repeat (3) @(posedge clk);
        chk("E_partial_beats", 64'(out_q.size()), 64'd7);
        for (int k = 0; k < 7 && k < out_q.size(); k++) begin
            chk("E_partial_data", 64'(out_q[k][DW-1:0]), 64'(model_mem[k]));
            chk("E_partial_last", 64'(out_q[k][DW]), 64'd0);
        end
        #1;
        rstn = 1'b1;
        m_tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_s_tready", 64'(s_tready), 64'd1);
        repeat (4) @(posedge clk);
        chk("post_reset_no_output", 64'(out_q.size()), 64'd7);

        load_frame(20, 1'b0, 16, 15, 1'b1);
        check_load("F", 16, 1'b0, 1'b0);
        unload("F", 16, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
